pipe_trace_monitor: RTL and testbench
=====================================

Name: pipe_trace_monitor

Overview:
Parametrised, synthesizable pipeline trace tracker for the MIPS in-order pipeline. It shadows PC/instruction through DEPTH stages, inserts bubbles on stall and squashes on flush, and emits a per-cycle retire event. It also keeps saturating cycle, retire, stall and bubble counters for the bench checkers and on-chip debug. It generalises the fixed 5-stage display tracker with stage count, hold/flush depth, counters and a stall-inference mode.

Parameters:
DEPTH, 5, number of tracked stages (stage 0 = IF, DEPTH-1 = WB); legal 3..8
DW, 32, instruction width
AW, 32, PC width
HOLD, 2, stages 0..HOLD-1 freeze on stall; stage HOLD receives a bubble; 1 <= HOLD < DEPTH
FLUSH, 2, flush kills the entries currently in stages 0..FLUSH-1; 1 <= FLUSH < DEPTH
CNT_W, 16, counter width
STALL_MODE, 0, 0 = use stall input; 1 = infer stall when fetch_pc equals the previous sampled fetch_pc

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low
fetch_pc  in  AW  PC presented by fetch
fetch_instr  in  DW  instruction presented by fetch; 0 = no-op/bubble
stall  in  1  hazard stall request (ignored when STALL_MODE=1)
flush  in  1  branch squash request
clear_stats  in  1  synchronous clear of all counters
stage_pc  out  DEPTH*AW  flattened stage PCs; stage i at [i*AW +: AW]
stage_instr  out  DEPTH*DW  flattened stage instructions
stage_valid  out  DEPTH  per-stage valid
retire_valid  out  1  = stage_valid[DEPTH-1]
retire_pc  out  AW  = stage PC of DEPTH-1
retire_instr  out  DW  = stage instruction of DEPTH-1
stall_seen  out  1  registered copy of the effective stall from the last edge
cycle_cnt, retire_cnt, stall_cnt, bubble_cnt  out  CNT_W each  saturating statistics

Behaviour:
- Reset is asynchronous and active-low. While reset=0 all stages, outputs, counters, pc_prv and the started flag are 0. No clock is needed to enter reset. Release is synchronous to the next edge.
- Effective stall: st = stall (mode 0), or st = started && fetch_pc==pc_prv (mode 1). pc_prv <= fetch_pc and started <= 1 on every edge.
- Normal edge (no st, no flush): stage0 <= {fetch_pc, fetch_instr, valid = fetch_instr!=0}; stage i <= stage i-1.
- Stall edge: stages 0..HOLD-1 hold. Stage HOLD <= bubble {pc 0, instr 0, valid 0}. Stages >HOLD shift.
- Flush edge: stage0 loads fetch normally. Stages 1..FLUSH <= bubble. Stages >FLUSH shift.
- Flush and st on the same edge: flush wins and st is ignored for that edge. stall_seen=0 and stall_cnt does not increment.
- Latency: fetch sampled at edge k appears on the retire outputs after edge k+DEPTH-1, with no stalls or flushes.
- Counters update on every edge after started. cycle_cnt +1. retire_cnt +1 if the new stage DEPTH-1 is valid; bubble_cnt +1 if it is not. stall_cnt +1 if effective st and no flush.
- All counters saturate at 2^CNT_W-1 and never wrap.
- clear_stats zeroes all counters on that edge and takes priority over increments. Stage contents are unaffected.
- Reset asserted mid-operation discards all in-flight entries. There is no partial retire.

Decomposition:
- Package pipe_trace_pkg holds:
  - the stage entry struct {pc, instr, valid};
  - the bubble constant;
  - STALL_MODE encodings (STALL_EXT=0, STALL_INFER=1).
- Sub-module sat_counter (CNT_W, inc, clr) is instantiated four times.
- The stage array is a generate loop over DEPTH with per-index hold/bubble/shift select.

Test Plan:
- Reset: run 10 cycles, then drive reset=0 between edges. All outputs must read 0 immediately. After release, retire_valid stays 0 for DEPTH-1 edges.
- Straight-line, defaults: PCs 0,4,...,80 with nonzero instrs. After edge 5, retire_pc=0 and retire_valid=1. After edge 9, retire_pc=16. retire_cnt=5 and bubble_cnt=4 at that point.
- External stall on the edge with PC 40 in IF: stage0/1 keep PC 40/36 and stage2 is invalid. stall_cnt=1. The PC-40 instruction retires one cycle later than in the straight-line run.
- STALL_MODE=1: fetch_pc sequence 56,60,60,64 gives the same stage pattern as an external stall at 60. stall_seen=1 for exactly one cycle. The stall input tied to 1 is ignored.
- Flush with stall on the same edge, PC 20 in IF: stages 1,2 become invalid, stage0 takes PC 24, stall_cnt unchanged. PCs 16 and 20 never retire, so retire_cnt is 2 lower than straight-line.
- CNT_W=4, 20 consecutive retires: retire_cnt holds at 15. Then clear_stats together with a retire gives 0 on that edge.

Source files
------------

// File: rtl/pipe_trace_monitor_pkg.sv
// Shared types and encodings for the pipeline trace monitor.
package pipe_trace_pkg;

  // Stall source selection for the STALL_MODE parameter.
  localparam int STALL_EXT   = 0;
  localparam int STALL_INFER = 1;

  // Reference widths of the MIPS pipeline being traced.
  localparam int TRACE_AW = 32;
  localparam int TRACE_DW = 32;

  // One pipeline stage slot as seen by the tracker.
  typedef struct packed {
    logic [TRACE_AW-1:0] pc;
    logic [TRACE_DW-1:0] instr;
    logic                valid;
  } stage_entry_t;

  // An empty slot: no PC, no-op instruction, not valid.
  localparam stage_entry_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/pipe_trace_monitor_if.sv
// Fetch-side inputs and trace/statistics outputs of the pipeline trace monitor.
interface pipe_trace_monitor_if #(
  parameter int DEPTH = 5,
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int CNT_W = 16
);

  logic [AW-1:0]       fetch_pc;
  logic [DW-1:0]       fetch_instr;
  logic                stall;
  logic                flush;
  logic                clear_stats;

  logic [DEPTH*AW-1:0] stage_pc;
  logic [DEPTH*DW-1:0] stage_instr;
  logic [DEPTH-1:0]    stage_valid;
  logic                retire_valid;
  logic [AW-1:0]       retire_pc;
  logic [DW-1:0]       retire_instr;
  logic                stall_seen;
  logic [CNT_W-1:0]    cycle_cnt;
  logic [CNT_W-1:0]    retire_cnt;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    bubble_cnt;

  // The side presenting fetch traffic and observing the trace.
  modport master (
    output fetch_pc, fetch_instr, stall, flush, clear_stats,
    input  stage_pc, stage_instr, stage_valid,
    input  retire_valid, retire_pc, retire_instr, stall_seen,
    input  cycle_cnt, retire_cnt, stall_cnt, bubble_cnt
  );

  // The monitor itself.
  modport slave (
    input  fetch_pc, fetch_instr, stall, flush, clear_stats,
    output stage_pc, stage_instr, stage_valid,
    output retire_valid, retire_pc, retire_instr, stall_seen,
    output cycle_cnt, retire_cnt, stall_cnt, bubble_cnt
  );

endinterface

// File: rtl/pipe_trace_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] MAX_COUNT = '1;

  logic [CNT_W-1:0] r_count;

  // Count up on request, stick at all-ones, and zero on clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX_COUNT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_trace_monitor.sv
// Pipeline trace monitor: shadows PC/instruction through DEPTH stages,
// models stall bubbles and flush squashes, and keeps saturating statistics.
// Legal ranges: DEPTH 3..8, 1 <= HOLD < DEPTH, 1 <= FLUSH < DEPTH.
module pipe_trace_monitor
  import pipe_trace_pkg::*;
#(
  parameter int DEPTH      = 5,
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int HOLD       = 2,
  parameter int FLUSH      = 2,
  parameter int CNT_W      = 16,
  parameter int STALL_MODE = STALL_EXT
) (
  input  logic                clock,
  input  logic                reset,
  pipe_trace_monitor_if.slave bus
);

  // Stage slot sized to this instance's PC and instruction widths.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          valid;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  entry_t        w_fetch;
  entry_t        w_stage [DEPTH];
  logic          w_flush;
  logic          w_st;
  logic          w_stall_eff;
  logic          w_tail_valid;
  logic [AW-1:0] r_pc_prv;
  logic          r_started;
  logic          r_stall_seen;

  assign w_fetch.pc    = bus.fetch_pc;
  assign w_fetch.instr = bus.fetch_instr;
  assign w_fetch.valid = (bus.fetch_instr != '0);

  assign w_flush = bus.flush;

  // In inference mode a fetch PC that did not move since the last edge is
  // taken as a stall; the very first edge after reset has no history.
  assign w_st = (STALL_MODE == STALL_INFER) ?
                (r_started && (bus.fetch_pc == r_pc_prv)) : bus.stall;

  // A flush overrides a stall on the same edge.
  assign w_stall_eff = w_st && !w_flush;

  // Remember last fetch PC, note that an edge has happened, and expose the stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc_prv     <= '0;
      r_started    <= 1'b0;
      r_stall_seen <= 1'b0;
    end else begin
      r_pc_prv     <= bus.fetch_pc;
      r_started    <= 1'b1;
      r_stall_seen <= w_stall_eff;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    localparam bit KILLED  = (i >= 1) && (i <= FLUSH);
    localparam bit FROZEN  = (i < HOLD);
    localparam bit BUBBLED = (i == HOLD);

    entry_t w_up;
    entry_t w_nxt;
    entry_t r_q;

    if (i == 0) begin : g_src
      assign w_up = w_fetch;
    end else begin : g_src
      assign w_up = w_stage[i-1];
    end

    // Pick this stage's next content: upstream by default, bubble or hold on flush/stall.
    always_comb begin
      w_nxt = w_up;
      if (w_flush) begin
        if (KILLED) begin
          w_nxt = BUBBLE;
        end
      end else if (w_st) begin
        if (FROZEN) begin
          w_nxt = r_q;
        end else if (BUBBLED) begin
          w_nxt = BUBBLE;
        end
      end
    end

    // Stage register; reset empties the slot so nothing half-retires.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_q <= BUBBLE;
      end else begin
        r_q <= w_nxt;
      end
    end

    assign w_stage[i] = r_q;

    if (i == DEPTH - 1) begin : g_tail
      assign w_tail_valid = w_nxt.valid;
    end
  end

  // Flatten the stage registers onto the trace buses.
  always_comb begin
    bus.stage_pc    = '0;
    bus.stage_instr = '0;
    bus.stage_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.stage_pc[i*AW +: AW]    = w_stage[i].pc;
      bus.stage_instr[i*DW +: DW] = w_stage[i].instr;
      bus.stage_valid[i]          = w_stage[i].valid;
    end
  end

  assign bus.retire_valid = w_stage[DEPTH-1].valid;
  assign bus.retire_pc    = w_stage[DEPTH-1].pc;
  assign bus.retire_instr = w_stage[DEPTH-1].instr;
  assign bus.stall_seen   = r_stall_seen;

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (r_started),
    .i_clr   (bus.clear_stats),
    .o_count (bus.cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_retire_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (r_started && w_tail_valid),
    .i_clr   (bus.clear_stats),
    .o_count (bus.retire_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (r_started && w_stall_eff),
    .i_clr   (bus.clear_stats),
    .o_count (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (r_started && !w_tail_valid),
    .i_clr   (bus.clear_stats),
    .o_count (bus.bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Bench for pipe_trace_monitor: a queue-based reference model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_pipe_trace_monitor;
  import pipe_trace_pkg::*;

  localparam int DEPTH = 5;
  localparam int HOLD  = 2;
  localparam int FLUSH = 2;

  logic        clock;
  logic        reset;
  logic [31:0] fetchPc;
  logic [31:0] fetchInstr;
  logic        stallIn;
  logic        flushIn;
  logic        clearIn;

  pipe_trace_monitor_if #(.DEPTH(DEPTH), .DW(32), .AW(32), .CNT_W(16)) busA ();
  pipe_trace_monitor_if #(.DEPTH(DEPTH), .DW(32), .AW(32), .CNT_W(4))  busB ();

  assign busA.fetch_pc    = fetchPc;
  assign busA.fetch_instr = fetchInstr;
  assign busA.stall       = stallIn;
  assign busA.flush       = flushIn;
  assign busA.clear_stats = clearIn;

  assign busB.fetch_pc    = fetchPc;
  assign busB.fetch_instr = fetchInstr;
  assign busB.stall       = 1'b1;
  assign busB.flush       = flushIn;
  assign busB.clear_stats = clearIn;

  pipe_trace_monitor #(
    .DEPTH(DEPTH), .DW(32), .AW(32), .HOLD(HOLD), .FLUSH(FLUSH),
    .CNT_W(16), .STALL_MODE(STALL_EXT)
  ) dutA (
    .clock (clock),
    .reset (reset),
    .bus   (busA)
  );

  pipe_trace_monitor #(
    .DEPTH(DEPTH), .DW(32), .AW(32), .HOLD(HOLD), .FLUSH(FLUSH),
    .CNT_W(4), .STALL_MODE(STALL_INFER)
  ) dutB (
    .clock (clock),
    .reset (reset),
    .bus   (busB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state: the pipeline as an ordered list, IF first.
  stage_entry_t pipeQ[$];
  int          mMode;
  int unsigned mCntMax;
  int unsigned mCycle, mRetire, mStall, mBubble;
  logic        mStarted;
  logic [31:0] mPcPrv;
  logic        mStallSeen;

  int activeDut;
  int checks;
  int passes;

  task automatic checkValue(input string name, input logic [255:0] actual,
                            input logic [255:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    pipeQ.delete();
    for (int i = 0; i < DEPTH; i++) pipeQ.push_back(STAGE_BUBBLE);
    mCycle     = 0;
    mRetire    = 0;
    mStall     = 0;
    mBubble    = 0;
    mStarted   = 1'b0;
    mPcPrv     = '0;
    mStallSeen = 1'b0;
  endtask

  task automatic modelStep(input logic [31:0] pc, input logic [31:0] instr,
                           input logic st, input logic fl, input logic clr);
    stage_entry_t fetched;
    logic effSt;
    fetched.pc    = pc;
    fetched.instr = instr;
    fetched.valid = (instr != 0);
    effSt = (mMode == STALL_INFER) ? (mStarted && (pc == mPcPrv)) : st;
    if (fl) begin
      for (int i = 0; i < FLUSH; i++) pipeQ[i] = STAGE_BUBBLE;
      pipeQ.push_front(fetched);
      void'(pipeQ.pop_back());
    end else if (effSt) begin
      pipeQ.insert(HOLD, STAGE_BUBBLE);
      void'(pipeQ.pop_back());
    end else begin
      pipeQ.push_front(fetched);
      void'(pipeQ.pop_back());
    end
    mStallSeen = effSt && !fl;
    if (clr) begin
      mCycle  = 0;
      mRetire = 0;
      mStall  = 0;
      mBubble = 0;
    end else if (mStarted) begin
      if (mCycle < mCntMax) mCycle++;
      if (pipeQ[DEPTH-1].valid) begin
        if (mRetire < mCntMax) mRetire++;
      end else begin
        if (mBubble < mCntMax) mBubble++;
      end
      if (mStallSeen && (mStall < mCntMax)) mStall++;
    end
    mPcPrv   = pc;
    mStarted = 1'b1;
  endtask

  task automatic sampleActive(output logic [159:0] sPc, output logic [159:0] sInstr,
                              output logic [4:0] sValid, output logic sRv,
                              output logic [31:0] sRpc, output logic [31:0] sRinstr,
                              output logic sSeen, output logic [15:0] sCyc,
                              output logic [15:0] sRet, output logic [15:0] sStl,
                              output logic [15:0] sBub);
    if (activeDut == 0) begin
      sPc = busA.stage_pc; sInstr = busA.stage_instr; sValid = busA.stage_valid;
      sRv = busA.retire_valid; sRpc = busA.retire_pc; sRinstr = busA.retire_instr;
      sSeen = busA.stall_seen;
      sCyc = busA.cycle_cnt; sRet = busA.retire_cnt;
      sStl = busA.stall_cnt; sBub = busA.bubble_cnt;
    end else begin
      sPc = busB.stage_pc; sInstr = busB.stage_instr; sValid = busB.stage_valid;
      sRv = busB.retire_valid; sRpc = busB.retire_pc; sRinstr = busB.retire_instr;
      sSeen = busB.stall_seen;
      sCyc = 16'(busB.cycle_cnt); sRet = 16'(busB.retire_cnt);
      sStl = 16'(busB.stall_cnt); sBub = 16'(busB.bubble_cnt);
    end
  endtask

  task automatic checkOutput();
    logic [159:0] aPc, aInstr, ePc, eInstr;
    logic [4:0]   aValid, eValid;
    logic         aRv, aSeen;
    logic [31:0]  aRpc, aRinstr;
    logic [15:0]  aCyc, aRet, aStl, aBub;
    sampleActive(aPc, aInstr, aValid, aRv, aRpc, aRinstr, aSeen, aCyc, aRet, aStl, aBub);
    for (int i = 0; i < DEPTH; i++) begin
      ePc[i*32 +: 32]    = pipeQ[i].pc;
      eInstr[i*32 +: 32] = pipeQ[i].instr;
      eValid[i]          = pipeQ[i].valid;
    end
    checkValue("stage_pc", aPc, ePc);
    checkValue("stage_instr", aInstr, eInstr);
    checkValue("stage_valid", aValid, eValid);
    checkValue("retire_valid", aRv, pipeQ[DEPTH-1].valid);
    checkValue("retire_pc", aRpc, pipeQ[DEPTH-1].pc);
    checkValue("retire_instr", aRinstr, pipeQ[DEPTH-1].instr);
    checkValue("stall_seen", aSeen, mStallSeen);
    checkValue("cycle_cnt", aCyc, mCycle);
    checkValue("retire_cnt", aRet, mRetire);
    checkValue("stall_cnt", aStl, mStall);
    checkValue("bubble_cnt", aBub, mBubble);
  endtask

  // Compare process: DUT against model once per cycle, away from the rising edge.
  always @(negedge clock) begin
    checkOutput();
  end

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                               input logic st, input logic fl, input logic clr);
    fetchPc    = pc;
    fetchInstr = instr;
    stallIn    = st;
    flushIn    = fl;
    clearIn    = clr;
    @(posedge clock);
    modelStep(pc, instr, st, fl, clr);
    #1;
  endtask

  // Assert reset between edges, verify everything is already zero, then release.
  task automatic doReset();
    logic [159:0] aPc, aInstr;
    logic [4:0]   aValid;
    logic         aRv, aSeen;
    logic [31:0]  aRpc, aRinstr;
    logic [15:0]  aCyc, aRet, aStl, aBub;
    #1 reset = 1'b0;
    modelReset();
    #1;
    sampleActive(aPc, aInstr, aValid, aRv, aRpc, aRinstr, aSeen, aCyc, aRet, aStl, aBub);
    checkValue("rst_stage_pc", aPc, 0);
    checkValue("rst_stage_valid", aValid, 0);
    checkValue("rst_retire_valid", aRv, 0);
    checkValue("rst_cycle_cnt", aCyc, 0);
    checkValue("rst_retire_cnt", aRet, 0);
    checkValue("rst_bubble_cnt", aBub, 0);
    fetchPc = '0; fetchInstr = '0; stallIn = 1'b0; flushIn = 1'b0; clearIn = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    logic        st, fl, clr;
    logic [31:0] instr;
    checks = 0; passes = 0;
    activeDut = 0; mMode = STALL_EXT; mCntMax = 32'h0000_FFFF;
    fetchPc = '0; fetchInstr = '0; stallIn = 1'b0; flushIn = 1'b0; clearIn = 1'b0;
    reset = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Straight line on the default configuration.
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(32'(4*(k-1)), 32'h2000_0000 | 32'(4*(k-1)), 1'b0, 1'b0, 1'b0);
      if (k == 5) begin
        checkValue("line_retire_valid_e5", busA.retire_valid, 1);
        checkValue("line_retire_pc_e5", busA.retire_pc, 0);
      end
      if (k == 9) begin
        checkValue("line_retire_pc_e9", busA.retire_pc, 16);
        checkValue("line_retire_cnt_e9", busA.retire_cnt, 5);
        checkValue("line_bubble_cnt_e9", busA.bubble_cnt, 4);
      end
    end

    // Mid-operation reset; nothing retires for DEPTH-1 edges after release.
    doReset();
    for (int k = 1; k <= DEPTH; k++) begin
      applyStimulus(32'h100 + 32'(4*k), 32'h2100_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
      checkValue("post_rst_retire_valid", busA.retire_valid, (k == DEPTH) ? 1 : 0);
    end

    // External stall with PC 40 in IF.
    doReset();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    pc = 32'd0;
    for (int k = 1; k <= 16; k++) begin
      st = (k == 12);
      applyStimulus(pc, 32'h2200_0000 | pc, st, 1'b0, 1'b0);
      if (!st) pc = pc + 32'd4;
      if (k == 12) begin
        checkValue("stall_stage0_pc", busA.stage_pc[0 +: 32], 40);
        checkValue("stall_stage1_pc", busA.stage_pc[32 +: 32], 36);
        checkValue("stall_stage2_valid", busA.stage_valid[2], 0);
        checkValue("stall_cnt_one", busA.stall_cnt, 1);
      end
      if (k == 16) begin
        checkValue("stall_late_retire_pc", busA.retire_pc, 40);
        checkValue("stall_late_retire_v", busA.retire_valid, 1);
      end
    end

    // Flush and stall together with PC 20 in IF.
    doReset();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      pc = 32'(4*(k-1));
      fl = (k == 7);
      applyStimulus(pc, 32'h2300_0000 | pc, fl, fl, 1'b0);
      if (k == 7) begin
        checkValue("flush_stage0_pc", busA.stage_pc[0 +: 32], 24);
        checkValue("flush_stage12_valid", busA.stage_valid[2:1], 0);
        checkValue("flush_stall_cnt", busA.stall_cnt, 0);
        checkValue("flush_stall_seen", busA.stall_seen, 0);
      end
    end
    checkValue("flush_retire_cnt", busA.retire_cnt, 8);

    // Randomized traffic on the default configuration.
    doReset();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    pc = 32'h0000_1000;
    for (int k = 0; k < 300; k++) begin
      st    = ($urandom_range(0, 4) == 0);
      fl    = ($urandom_range(0, 7) == 0);
      clr   = ($urandom_range(0, 29) == 0);
      instr = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      applyStimulus(pc, instr, st, fl, clr);
      if (!st || fl) pc = pc + 32'd4;
    end

    // Stall-inference configuration with a 4-bit counter.
    activeDut = 1; mMode = STALL_INFER; mCntMax = 32'd15;
    doReset();
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    pc = 32'd40;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(pc, 32'h3000_0000 | pc, 1'b0, 1'b0, 1'b0);
      if (k == 7) begin
        checkValue("infer_stage0_pc", busB.stage_pc[0 +: 32], 60);
        checkValue("infer_stage1_pc", busB.stage_pc[32 +: 32], 56);
        checkValue("infer_stage2_valid", busB.stage_valid[2], 0);
        checkValue("infer_stall_seen", busB.stall_seen, 1);
        checkValue("infer_stall_cnt", busB.stall_cnt, 1);
      end
      if (k == 8) checkValue("infer_stall_seen_off", busB.stall_seen, 0);
      if (k != 6) pc = pc + 32'd4;
    end
    for (int k = 0; k < 30; k++) begin
      applyStimulus(pc, 32'h3100_0000 | pc, 1'b0, 1'b0, 1'b0);
      pc = pc + 32'd4;
    end
    checkValue("sat_retire_cnt", busB.retire_cnt, 15);
    checkValue("sat_cycle_cnt", busB.cycle_cnt, 15);
    applyStimulus(pc, 32'h3200_0000 | pc, 1'b0, 1'b0, 1'b1);
    pc = pc + 32'd4;
    checkValue("clear_retire_cnt", busB.retire_cnt, 0);
    checkValue("clear_cycle_cnt", busB.cycle_cnt, 0);
    applyStimulus(pc, 32'h3200_0000 | pc, 1'b0, 1'b0, 1'b0);
    pc = pc + 32'd4;
    checkValue("after_clear_retire", busB.retire_cnt, 1);

    // Randomized traffic on the inference configuration.
    for (int k = 0; k < 200; k++) begin
      fl    = ($urandom_range(0, 9) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      instr = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      applyStimulus(pc, instr, 1'b0, fl, clr);
      if ($urandom_range(0, 3) != 0) pc = pc + 32'd4;
    end

    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
